mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU in cycles.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  E-stage issue strobe for the operation on mdop.
REQ-006 mdop  input  4  operation code: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO (+MADD, MADDU, MSUB, MSUBU under REQ-024).
REQ-007 rs  input  32  forwarded rs operand from the E-stage forwarding mux.
REQ-008 rt  input  32  forwarded rt operand from the E-stage forwarding mux.
REQ-009 busy  output  1  high while a multi-cycle operation is in flight.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.

Function
REQ-012 States IDLE and RUN; IDLE->RUN on start with a multi-cycle mdop; RUN->IDLE when cycle counter reaches 1.
REQ-013 Operands and mdop latched at the start edge; later rs/rt changes do not affect the result.
REQ-014 Start at edge t: busy high for cycles t+1..t+N (N = MULT_CYCLES or DIV_CYCLES); hi/lo update at edge t+N, the same edge busy falls.
REQ-015 MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product of rs and rt.
REQ-016 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000.
REQ-018 Divisor zero: operation runs full DIV_CYCLES, hi and lo unchanged.
REQ-019 MTHI/MTLO: hi or lo = rs at the start edge, single cycle, busy stays low.
REQ-020 start while busy: ignored (hazard unit stalls on start|busy, so it must not occur; no state change if it does).
REQ-021 start with mdop NONE or unknown code: no state change.
REQ-022 hi/lo are combinationally stable between update edges; MFHI/MFLO read them directly.

Reset
REQ-023 reset asserted at any time, including mid-operation: state IDLE, counter 0, busy 0, hi 0, lo 0, in-flight result discarded.

Configuration
REQ-024 Macro MDU_MADD_EN: defined -> MADD/MADDU/MSUB/MSUBU accepted, {hi,lo} = {hi,lo} +/- product at the completion edge, MULT_CYCLES latency; undefined -> those codes treated as NONE.

Structure
REQ-025 mdop encodings, MULT_CYCLES/DIV_CYCLES defaults, and the state encoding live in the shared CPU definitions package used by CTRL.
REQ-026 One sub-module, mdu_arith: combinational product/quotient/remainder from the latched operands; mult_div_unit owns FSM, counter, hi/lo.

Verification
REQ-027 MULT rs=0xFFFFFFFE(-2), rt=3, start at edge 0 -> busy high cycles 1-5, edge 5 hi=0xFFFFFFFF lo=0xFFFFFFFA, busy low.
REQ-028 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE lo=0x00000001.
REQ-029 DIV rs=-7 (0xFFFFFFF9), rt=2 -> after 10 cycles lo=0xFFFFFFFD hi=0xFFFFFFFF; then DIVU rs=7 rt=0 -> hi/lo unchanged after 10 cycles.
REQ-030 MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 on consecutive edges -> hi/lo updated on each edge, busy never high.
REQ-031 DIV started, reset pulsed at cycle 4 -> busy, hi, lo 0 immediately; no update at original completion edge.
REQ-032 MDU_MADD_EN defined, hi=0 lo=10, MADD rs=3 rt=4 -> after 5 cycles lo=22 hi=0; undefined -> hi/lo unchanged, busy low.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// ============================================================================
// Module : mult_div_unit_pkg
// Brief  : Shared CPU definitions for the multiply/divide unit: mdop codes,
//          default latencies, FSM encoding and opcode classification helpers.
//          Optional feature macro: MDU_MADD_EN (multiply-accumulate codes).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_div_unit_pkg;

    localparam int c_xlen             = 32;
    localparam int c_mdop_w           = 4;
    localparam int c_mult_cycles_def  = 5;
    localparam int c_div_cycles_def   = 10;

    typedef enum logic [c_mdop_w-1:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } mdop_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Multiply-accumulate codes only count as multiplies when the feature is built in
    function automatic logic op_is_mult(input logic [c_mdop_w-1:0] op);
        case (op)
            OP_MULT, OP_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_div(input logic [c_mdop_w-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_if.sv
// ============================================================================
// Module : mult_div_unit_if
// Brief  : E-stage issue bus and HI/LO read-back between pipeline and MDU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic                 start;
    logic [c_mdop_w-1:0]  mdop;
    logic [c_xlen-1:0]    rs;
    logic [c_xlen-1:0]    rt;
    logic                 busy;
    logic [c_xlen-1:0]    hi;
    logic [c_xlen-1:0]    lo;

    modport master (output start, mdop, rs, rt, input busy, hi, lo);
    modport slave  (input start, mdop, rs, rt, output busy, hi, lo);
endinterface

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// Module : mdu_arith
// Brief  : Combinational product/quotient/remainder from the latched operands.
//          MDU_MADD_EN adds the accumulate/subtract forms against HI/LO.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_arith
    import mult_div_unit_pkg::*;
(
    input  mdop_e              i_op,
    input  logic [c_xlen-1:0]  i_a,
    input  logic [c_xlen-1:0]  i_b,
    input  logic [c_xlen-1:0]  i_hi,
    input  logic [c_xlen-1:0]  i_lo,
    output logic [c_xlen-1:0]  o_hi,
    output logic [c_xlen-1:0]  o_lo,
    output logic               o_wr_en
);

    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic [c_xlen-1:0]  w_b_safe;
    logic [c_xlen-1:0]  w_a_mag;
    logic [c_xlen-1:0]  w_b_mag;
    logic [c_xlen-1:0]  w_q_mag;
    logic [c_xlen-1:0]  w_r_mag;
    logic [c_xlen-1:0]  w_quo_s;
    logic [c_xlen-1:0]  w_rem_s;
    logic               w_b_zero;

    // Sign-extended 64x64 multiply: the low 64 bits equal the signed product
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    assign w_b_zero = (i_b == '0);
    assign w_b_safe = w_b_zero ? 32'd1 : i_b;

    // Magnitude division keeps 0x80000000 / -1 well defined (wraps to 0x80000000)
    assign w_a_mag = i_a[31] ? -i_a : i_a;
    assign w_b_mag = i_b[31] ? -i_b : w_b_safe;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;
    assign w_quo_s = (i_a[31] ^ i_b[31]) ? -w_q_mag : w_q_mag;
    assign w_rem_s = i_a[31] ? -w_r_mag : w_r_mag;

`ifdef MDU_MADD_EN
    logic [63:0] w_acc;
    assign w_acc = {i_hi, i_lo};
`else
    logic w_unused_acc;
    assign w_unused_acc = ^{i_hi, i_lo};
`endif

    always_comb begin
        o_hi    = '0;
        o_lo    = '0;
        o_wr_en = 1'b0;
        case (i_op)
            OP_MULT: begin
                {o_hi, o_lo} = w_prod_s;
                o_wr_en      = 1'b1;
            end
            OP_MULTU: begin
                {o_hi, o_lo} = w_prod_u;
                o_wr_en      = 1'b1;
            end
            OP_DIV: begin
                o_lo    = w_quo_s;
                o_hi    = w_rem_s;
                o_wr_en = !w_b_zero;
            end
            OP_DIVU: begin
                o_lo    = i_a / w_b_safe;
                o_hi    = i_a % w_b_safe;
                o_wr_en = !w_b_zero;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                {o_hi, o_lo} = w_acc + w_prod_s;
                o_wr_en      = 1'b1;
            end
            OP_MADDU: begin
                {o_hi, o_lo} = w_acc + w_prod_u;
                o_wr_en      = 1'b1;
            end
            OP_MSUB: begin
                {o_hi, o_lo} = w_acc - w_prod_s;
                o_wr_en      = 1'b1;
            end
            OP_MSUBU: begin
                {o_hi, o_lo} = w_acc - w_prod_u;
                o_wr_en      = 1'b1;
            end
`endif
            default: begin
                o_wr_en = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module : mult_div_unit
// Brief  : Multi-cycle MIPS multiply/divide unit owning HI/LO, busy FSM and
//          latency counter. MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = c_mult_cycles_def,
    parameter int DIV_CYCLES  = c_div_cycles_def
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mult_div_unit_if.slave     bus
);

    localparam int c_max_cyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

    mdu_state_e          r_state;
    mdu_state_e          w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_xlen-1:0]   r_hi;
    logic [c_xlen-1:0]   r_lo;
    logic [c_xlen-1:0]   w_hi_nxt;
    logic [c_xlen-1:0]   w_lo_nxt;
    mdop_e               r_op;
    logic [c_xlen-1:0]   r_a;
    logic [c_xlen-1:0]   r_b;
    logic                w_latch;
    logic [c_xlen-1:0]   w_res_hi;
    logic [c_xlen-1:0]   w_res_lo;
    logic                w_res_wr;

    mdu_arith u_arith (
        .i_op    (r_op),
        .i_a     (r_a),
        .i_b     (r_b),
        .i_hi    (r_hi),
        .i_lo    (r_lo),
        .o_hi    (w_res_hi),
        .o_lo    (w_res_lo),
        .o_wr_en (w_res_wr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= OP_NONE;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_latch) begin
                r_op <= mdop_e'(bus.mdop);
                r_a  <= bus.rs;
                r_b  <= bus.rt;
            end
        end
    end

    // Starts arriving while RUN are dropped; the hazard unit should never issue them
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (op_is_mult(bus.mdop)) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = c_cnt_w'(MULT_CYCLES);
                        w_latch     = 1'b1;
                    end else if (op_is_div(bus.mdop)) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = c_cnt_w'(DIV_CYCLES);
                        w_latch     = 1'b1;
                    end else if (bus.mdop == OP_MTHI) begin
                        w_hi_nxt = bus.rs;
                    end else if (bus.mdop == OP_MTLO) begin
                        w_lo_nxt = bus.rs;
                    end
                end
            end
            ST_RUN: begin
                if (r_cnt <= c_cnt_w'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    if (w_res_wr) begin
                        w_hi_nxt = w_res_hi;
                        w_lo_nxt = w_res_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

`default_nettype wire
